// File: rtl/mdu_sequencer.sv
// Purpose: sequences the shared multiply/divide datapath for the execute stage, one op at a time.
// Latency: response valid MUL_LAT+1 (multiply) or DIV_LAT+1 (divide) cycles after the accept edge.
// Backpressure: the response is held while iRespReady is low; no request is accepted until back in IDLE.
//
// Optional feature macro: MDU_DIVZERO_BYPASS_EN (divide by zero answers in one cycle with all-ones).
//
// Ports:
//   iClk, iRst                      clock, asynchronous active-high reset
//   iReqValid/oReqReady             request handshake; iReqOp 0=mul-high, 1=divide
//   iReqSrc0, iReqSrc1              operands
//   iFlush                          abort any in-flight or pending-response operation
//   oMduSrc0/oMduSrc1/oMduOperation registered operands and op select to the datapath
//   iMduResult                      datapath result
//   oRespValid/iRespReady, oResp    response handshake and captured result
//   oBusy                           high while not IDLE
//   oDivByZero                      qualifies oResp: divide by zero (bypass build only)
module mdu_sequencer #(
    parameter int MUL_LAT = 1,
    parameter int DIV_LAT = 34,
    parameter int CNT_W   = 6
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iReqValid,
    output logic        oReqReady,
    input  logic        iReqOp,
    input  logic [31:0] iReqSrc0,
    input  logic [31:0] iReqSrc1,
    input  logic        iFlush,
    output logic [31:0] oMduSrc0,
    output logic [31:0] oMduSrc1,
    output logic        oMduOperation,
    input  logic [31:0] iMduResult,
    output logic        oRespValid,
    input  logic        iRespReady,
    output logic [31:0] oResp,
    output logic        oBusy,
    output logic        oDivByZero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             runDone;
    logic             respTaken;
    logic             bypassHit;
    logic             bypassPend;

    // Ready is also forced low during reset so every output reads 0 then.
    assign oReqReady = (state == IDLE) && !iFlush && !iRst;
    assign accept    = iReqValid && oReqReady;
    assign oBusy     = (state != IDLE);
    assign runDone   = (state == RUN) && !iFlush && (cnt == '0);
    assign respTaken = (state == RESP) && (iFlush || (oRespValid && iRespReady));

`ifdef MDU_DIVZERO_BYPASS_EN
    assign bypassHit = iReqOp && (iReqSrc1 == 32'd0);

    // A bypassed divide sits in RESP for one cycle before its response appears,
    // so the all-ones answer lands one edge after the accept.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            bypassPend <= 1'b0;
        end else begin
            bypassPend <= accept && bypassHit;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oDivByZero <= 1'b0;
        end else if (accept) begin
            oDivByZero <= 1'b0;
        end else if (bypassPend && !iFlush) begin
            oDivByZero <= 1'b1;
        end
    end
`else
    assign bypassHit  = 1'b0;
    assign bypassPend = 1'b0;
    assign oDivByZero = 1'b0;
`endif

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = bypassHit ? RESP : RUN;
                end
            end
            RUN: begin
                if (iFlush) begin
                    stateNext = IDLE;
                end else if (cnt == '0) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                if (respTaken) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Operands stay on the datapath until the next accept, even through IDLE.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oMduSrc0      <= 32'd0;
            oMduSrc1      <= 32'd0;
            oMduOperation <= 1'b0;
            cnt           <= '0;
        end else if (accept) begin
            oMduSrc0      <= iReqSrc0;
            oMduSrc1      <= iReqSrc1;
            oMduOperation <= iReqOp;
            cnt           <= iReqOp ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
        end else if ((state == RUN) && !iFlush && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oResp      <= 32'd0;
            oRespValid <= 1'b0;
        end else if (bypassPend && !iFlush) begin
            oResp      <= 32'hFFFF_FFFF;
            oRespValid <= 1'b1;
        end else if (runDone) begin
            oResp      <= iMduResult;
            oRespValid <= 1'b1;
        end else if (respTaken) begin
            oRespValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: a timestamp-based reference model compared every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_mdu_sequencer;

    localparam int MUL_LAT = 1;
    localparam int DIV_LAT = 34;
`ifdef MDU_DIVZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iReqValid;
    logic        oReqReady;
    logic        iReqOp;
    logic [31:0] iReqSrc0;
    logic [31:0] iReqSrc1;
    logic        iFlush;
    logic [31:0] oMduSrc0;
    logic [31:0] oMduSrc1;
    logic        oMduOperation;
    logic [31:0] iMduResult;
    logic        oRespValid;
    logic        iRespReady;
    logic [31:0] oResp;
    logic        oBusy;
    logic        oDivByZero;

    int checks = 0;
    int errors = 0;
    bit cmpEn  = 1'b0;

    always #5 iClk = ~iClk;

    mdu_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
        .iClk(iClk), .iRst(iRst),
        .iReqValid(iReqValid), .oReqReady(oReqReady), .iReqOp(iReqOp),
        .iReqSrc0(iReqSrc0), .iReqSrc1(iReqSrc1), .iFlush(iFlush),
        .oMduSrc0(oMduSrc0), .oMduSrc1(oMduSrc1), .oMduOperation(oMduOperation),
        .iMduResult(iMduResult), .oRespValid(oRespValid), .iRespReady(iRespReady),
        .oResp(oResp), .oBusy(oBusy), .oDivByZero(oDivByZero)
    );

    function automatic logic [31:0] refResult(input logic op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        if (!op) return p[63:32];
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Datapath stand-in: garbage until its latency has elapsed since the operands were applied.
    int age = 0;
    always @(posedge iClk or posedge iRst) begin
        if (iRst) age <= 0;
        else if (iReqValid && oReqReady) age <= 0;
        else if (age < 1000) age <= age + 1;
    end
    assign iMduResult = (age >= (oMduOperation ? DIV_LAT : MUL_LAT))
                        ? refResult(oMduOperation, oMduSrc0, oMduSrc1) : 32'hDEAD_BEEF;

    // Reference model: an accepted op owes its response at a fixed cycle number;
    // it stays busy until that response is taken or the op is flushed.
    int          cyc = 0;
    int          tDue = 0;
    bit          mBusy, mRespValid, mDbz, mOp, mByp;
    logic [31:0] mResp, mSrc0, mSrc1;

    always @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            mBusy <= 1'b0; mRespValid <= 1'b0; mDbz <= 1'b0; mOp <= 1'b0; mByp <= 1'b0;
            mResp <= 32'd0; mSrc0 <= 32'd0; mSrc1 <= 32'd0; tDue <= 0;
        end else begin
            cyc <= cyc + 1;
            if (!mBusy) begin
                if (iReqValid && !iFlush) begin
                    mBusy <= 1'b1; mSrc0 <= iReqSrc0; mSrc1 <= iReqSrc1; mOp <= iReqOp; mDbz <= 1'b0;
                    mByp  <= BYPASS && iReqOp && (iReqSrc1 == 32'd0);
                    if (BYPASS && iReqOp && (iReqSrc1 == 32'd0)) tDue <= cyc + 2;
                    else tDue <= cyc + 2 + (iReqOp ? DIV_LAT : MUL_LAT);
                end
            end else if (mRespValid) begin
                if (iFlush || iRespReady) begin
                    mRespValid <= 1'b0; mBusy <= 1'b0;
                end
            end else if (iFlush) begin
                mBusy <= 1'b0;
            end else if (cyc + 1 == tDue) begin
                mRespValid <= 1'b1;
                mResp      <= mByp ? 32'hFFFF_FFFF : refResult(mOp, mSrc0, mSrc1);
                mDbz       <= mByp;
            end
        end
    end

    always @(negedge iClk) begin
        if (cmpEn) begin
            chk("cyc_ready", oReqReady, !mBusy && !iFlush && !iRst);
            chk("cyc_busy", oBusy, mBusy);
            chk("cyc_rvld", oRespValid, mRespValid);
            chk("cyc_resp", oResp, mResp);
            chk("cyc_dbz", oDivByZero, mDbz);
            chk("cyc_src0", oMduSrc0, mSrc0);
            chk("cyc_src1", oMduSrc1, mSrc1);
            chk("cyc_op", oMduOperation, mOp);
        end
    end

    // Issue one op (caller is #1 after an edge with the DUT idle), measure latency,
    // optionally hold the response under backpressure, then take it.
    task automatic doOp(input string name, input logic op, input logic [31:0] a, input logic [31:0] b,
                        input int expLat, input logic [31:0] expResp, input logic expDbz, input int hold);
        int n;
        iReqValid = 1'b1; iReqOp = op; iReqSrc0 = a; iReqSrc1 = b;
        @(posedge iClk); #1;
        iReqValid = 1'b0;
        n = 0;
        while (!oRespValid && n < 100) begin
            @(posedge iClk); #1;
            n++;
        end
        chk({name, "_lat"}, n, expLat);
        chk({name, "_resp"}, oResp, expResp);
        chk({name, "_dbz"}, oDivByZero, expDbz);
        if (hold > 0) begin
            iReqValid = 1'b1; iReqOp = 1'b0; iReqSrc0 = 32'h1234_5678; iReqSrc1 = 32'h9;
            repeat (hold) begin
                @(posedge iClk); #1;
            end
            chk({name, "_hold_vld"}, oRespValid, 1);
            chk({name, "_hold_resp"}, oResp, expResp);
            chk({name, "_hold_src0"}, oMduSrc0, a);
            iReqValid = 1'b0;
        end
        iRespReady = 1'b1;
        @(posedge iClk); #1;
        iRespReady = 1'b0;
        chk({name, "_idle_busy"}, oBusy, 0);
        chk({name, "_idle_rvld"}, oRespValid, 0);
        @(posedge iClk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit sawVld;
        iRst = 1'b0; iReqValid = 1'b0; iReqOp = 1'b0; iReqSrc0 = 32'd0; iReqSrc1 = 32'd0;
        iFlush = 1'b0; iRespReady = 1'b0;
        #2 iRst = 1'b1;
        repeat (2) @(posedge iClk);
        #1;
        cmpEn = 1'b1;
        chk("rst_ready", oReqReady, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_rvld", oRespValid, 0);
        chk("rst_resp", oResp, 0);
        iRst = 1'b0;
        #1;
        chk("rst_release_ready", oReqReady, 1);
        @(posedge iClk); #1;

        doOp("mul3x5", 1'b0, 32'd3, 32'd5, 2, 32'h0, 1'b0, 0);
        doOp("mulmsb", 1'b0, 32'h8000_0000, 32'h8000_0000, 2, 32'h4000_0000, 1'b0, 0);
        doOp("div100_7", 1'b1, 32'd100, 32'd7, 35, 32'd14, 1'b0, 5);
`ifdef MDU_DIVZERO_BYPASS_EN
        doOp("div9_0", 1'b1, 32'd9, 32'd0, 1, 32'hFFFF_FFFF, 1'b1, 0);
`else
        doOp("div9_0", 1'b1, 32'd9, 32'd0, 35, 32'hFFFF_FFFF, 1'b0, 0);
`endif
        doOp("div50_5", 1'b1, 32'd50, 32'd5, 35, 32'd10, 1'b0, 0);

        // Flush a divide ten edges in; its response must never appear.
        iReqValid = 1'b1; iReqOp = 1'b1; iReqSrc0 = 32'd1000; iReqSrc1 = 32'd3;
        @(posedge iClk); #1;
        iReqValid = 1'b0;
        repeat (10) @(posedge iClk);
        #1;
        iFlush = 1'b1;
        @(posedge iClk); #1;
        iFlush = 1'b0;
        chk("flush_busy", oBusy, 0);
        sawVld = 1'b0;
        repeat (40) begin
            @(posedge iClk); #1;
            if (oRespValid) sawVld = 1'b1;
        end
        chk("flush_no_resp", sawVld, 0);

        // Flush beats a simultaneous request in IDLE.
        iFlush = 1'b1; iReqValid = 1'b1; iReqOp = 1'b0; iReqSrc0 = 32'd77; iReqSrc1 = 32'd88;
        #1;
        chk("flushreq_ready", oReqReady, 0);
        @(posedge iClk); #1;
        iFlush = 1'b0; iReqValid = 1'b0;
        chk("flushreq_busy", oBusy, 0);
        chk("flushreq_src0", oMduSrc0, 32'd1000);
        @(posedge iClk); #1;

        doOp("mulmax2", 1'b0, 32'hFFFF_FFFF, 32'd2, 2, 32'h1, 1'b0, 0);

        // Reset asserted mid-divide clears everything at once.
        iReqValid = 1'b1; iReqOp = 1'b1; iReqSrc0 = 32'd100; iReqSrc1 = 32'd7;
        @(posedge iClk); #1;
        iReqValid = 1'b0;
        repeat (5) @(posedge iClk);
        #1;
        iRst = 1'b1;
        #1;
        chk("midrst_busy", oBusy, 0);
        chk("midrst_ready", oReqReady, 0);
        chk("midrst_src0", oMduSrc0, 0);
        chk("midrst_src1", oMduSrc1, 0);
        chk("midrst_op", oMduOperation, 0);
        @(posedge iClk); #1;
        iRst = 1'b0;
        #1;
        chk("midrst_release_ready", oReqReady, 1);
        @(posedge iClk); #1;

        doOp("div21_4", 1'b1, 32'd21, 32'd4, 35, 32'd5, 1'b0, 2);

        cmpEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
